// File: rtl/hazard_stall_ctrl_if.sv
// rtl/hazard_stall_ctrl_if.sv - hazard/stall sequencer signal bundle
// Purpose: groups the pipeline-side hazard inputs and the stall/flush/hold
//   controls exchanged between the MIPS pipeline and hazard_stall_ctrl.
// Parameters: REG_W register-specifier width; CNT_W statistics counter width
//   (present only when HAZARD_STATS_EN is defined).
// Modports: master = pipeline (drives hazard inputs, receives controls),
//   slave = hazard_stall_ctrl.
// Signals: id_rs, id_rt, id_uses_rt, id_is_branch, branch_taken, ex_mem_read,
//   ex_reg_write, ex_write_reg, mem_mem_read, mem_write_reg, dmem_req,
//   dmem_ready -> controller; pc_write, if_id_write, id_ex_bubble,
//   if_id_flush, pipe_hold, hazard_state [, stall_cycles, hold_cycles] <- controller.
interface hazard_stall_ctrl_if #(
  parameter int REG_W = 5
`ifdef HAZARD_STATS_EN
  , parameter int CNT_W = 16
`endif
);
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rt;
  logic             id_is_branch;
  logic             branch_taken;
  logic             ex_mem_read;
  logic             ex_reg_write;
  logic [REG_W-1:0] ex_write_reg;
  logic             mem_mem_read;
  logic [REG_W-1:0] mem_write_reg;
  logic             dmem_req;
  logic             dmem_ready;
  logic             pc_write;
  logic             if_id_write;
  logic             id_ex_bubble;
  logic             if_id_flush;
  logic             pipe_hold;
  logic [1:0]       hazard_state;
`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] hold_cycles;
`endif

  modport master (
    output id_rs, id_rt, id_uses_rt, id_is_branch, branch_taken,
           ex_mem_read, ex_reg_write, ex_write_reg, mem_mem_read,
           mem_write_reg, dmem_req, dmem_ready,
    input  pc_write, if_id_write, id_ex_bubble, if_id_flush, pipe_hold,
           hazard_state
`ifdef HAZARD_STATS_EN
    , input stall_cycles, hold_cycles
`endif
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, id_is_branch, branch_taken,
           ex_mem_read, ex_reg_write, ex_write_reg, mem_mem_read,
           mem_write_reg, dmem_req, dmem_ready,
    output pc_write, if_id_write, id_ex_bubble, if_id_flush, pipe_hold,
           hazard_state
`ifdef HAZARD_STATS_EN
    , output stall_cycles, hold_cycles
`endif
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - pipeline hazard stall/bubble/flush/hold sequencer
// Purpose: detects hazards forwarding cannot cover and sequences PC/IF-ID
//   stalls, ID/EX bubbles, IF/ID flushes on taken branches and whole-pipe
//   holds during multi-cycle data-memory accesses.
// Ports: clk, rst_n (async active-low), bus (hazard_stall_ctrl_if.slave).
// Optional: HAZARD_STATS_EN adds saturating stall_cycles/hold_cycles counters.
module hazard_stall_ctrl (
  input  logic                 clk,
  input  logic                 rst_n,
  hazard_stall_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    STALL2   = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t state, state_next;
  state_t resume, resume_next;
  state_t eval_state;

  logic match_ex, match_mem;
  logic haz_lu, haz_br1, haz_brl, haz_brm;
  logic mem_busy;

  logic pc_write, if_id_write, id_ex_bubble, if_id_flush, pipe_hold;

  // Register 0 is hardwired, so a $zero destination never creates a hazard.
  assign match_ex  = (bus.ex_write_reg != '0) &&
                     ((bus.ex_write_reg == bus.id_rs) ||
                      (bus.id_uses_rt && (bus.ex_write_reg == bus.id_rt)));
  assign match_mem = (bus.mem_write_reg != '0) &&
                     ((bus.mem_write_reg == bus.id_rs) ||
                      (bus.id_uses_rt && (bus.mem_write_reg == bus.id_rt)));

  assign haz_lu   = bus.ex_mem_read & match_ex;
  assign haz_br1  = bus.id_is_branch & bus.ex_reg_write & match_ex & ~bus.ex_mem_read;
  assign haz_brl  = bus.id_is_branch & bus.ex_mem_read & match_ex;
  assign haz_brm  = bus.id_is_branch & bus.mem_mem_read & match_mem;
  assign mem_busy = bus.dmem_req & ~bus.dmem_ready;

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    pipe_hold    = 1'b0;
    state_next   = state;
    resume_next  = resume;
    // On the release cycle of a memory wait, behave exactly like the state
    // that was interrupted.
    eval_state   = (state == MEM_WAIT) ? resume : state;

    if (!rst_n) begin
      state_next  = RUN;
      resume_next = RUN;
    end else if ((state == MEM_WAIT) && !bus.dmem_ready) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      pipe_hold   = 1'b1;
    end else begin
      case (eval_state)
        RUN: begin
          state_next = RUN;
          if (mem_busy) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            pipe_hold   = 1'b1;
            state_next  = MEM_WAIT;
            resume_next = RUN;
          end else if (haz_brl) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            state_next   = STALL2;
          end else if (haz_lu | haz_br1 | haz_brm) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
          end else if (bus.id_is_branch && bus.branch_taken) begin
            if_id_flush = 1'b1;
          end
        end
        STALL2: begin
          if (mem_busy) begin
            // The second bubble stays pending across the memory wait.
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            pipe_hold   = 1'b1;
            state_next  = MEM_WAIT;
            resume_next = STALL2;
          end else begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            state_next   = RUN;
          end
        end
        default: begin
          state_next  = RUN;
          resume_next = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      resume <= RUN;
    end else begin
      state  <= state_next;
      resume <= resume_next;
    end
  end

  assign bus.pc_write     = pc_write;
  assign bus.if_id_write  = if_id_write;
  assign bus.id_ex_bubble = id_ex_bubble;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.pipe_hold    = pipe_hold;
  assign bus.hazard_state = state;

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.stall_cycles <= '0;
      bus.hold_cycles  <= '0;
    end else begin
      if (id_ex_bubble && !(&bus.stall_cycles))
        bus.stall_cycles <= bus.stall_cycles + 1'b1;
      if (pipe_hold && !(&bus.hold_cycles))
        bus.hold_cycles <= bus.hold_cycles + 1'b1;
    end
  end
`else
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - directed self-checking bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  // {pc_write, if_id_write, id_ex_bubble, if_id_flush, pipe_hold, hazard_state}
  localparam logic [6:0] NORM0  = 7'b1100000;
  localparam logic [6:0] STALL0 = 7'b0010000;
  localparam logic [6:0] STALL1 = 7'b0010001;
  localparam logic [6:0] STALL2 = 7'b0010010;
  localparam logic [6:0] FLUSH0 = 7'b1101000;
  localparam logic [6:0] HOLD0  = 7'b0000100;
  localparam logic [6:0] HOLD1  = 7'b0000101;
  localparam logic [6:0] HOLD2  = 7'b0000110;
  localparam logic [6:0] NORM2  = 7'b1100010;

  hazard_stall_ctrl_if bus ();

  hazard_stall_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] outs();
    return {bus.pc_write, bus.if_id_write, bus.id_ex_bubble,
            bus.if_id_flush, bus.pipe_hold, bus.hazard_state};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_in();
    bus.id_rs = '0; bus.id_rt = '0; bus.id_uses_rt = 1'b0;
    bus.id_is_branch = 1'b0; bus.branch_taken = 1'b0;
    bus.ex_mem_read = 1'b0; bus.ex_reg_write = 1'b0; bus.ex_write_reg = '0;
    bus.mem_mem_read = 1'b0; bus.mem_write_reg = '0;
    bus.dmem_req = 1'b0; bus.dmem_ready = 1'b0;
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled 3
  // units later, well clear of the next edge.
  task automatic settle();
    #3;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_brl();
    clear_in();
    bus.id_is_branch = 1'b1; bus.ex_mem_read = 1'b1;
    bus.ex_write_reg = 5'd9; bus.id_rt = 5'd9; bus.id_uses_rt = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_in();
    #2;
    check("reset_outputs", outs(), NORM0);
`ifdef HAZARD_STATS_EN
    check("reset_stall_cnt", bus.stall_cycles, 0);
    check("reset_hold_cnt", bus.hold_cycles, 0);
`endif
    tick();
    rst_n = 1'b1;
    settle();
    check("idle_run", outs(), NORM0);

    // Load-use on rs: one bubble, state stays RUN
    tick();
    bus.ex_mem_read = 1'b1; bus.ex_write_reg = 5'd8; bus.id_rs = 5'd8;
    settle();
    check("lu_stall", outs(), STALL0);
    tick();
    clear_in();
    settle();
    check("lu_released", outs(), NORM0);

    // Load-use on rt ignored when rt is not a source
    tick();
    bus.ex_mem_read = 1'b1; bus.ex_write_reg = 5'd4; bus.id_rt = 5'd4;
    settle();
    check("lu_rt_unused", outs(), NORM0);

    // $zero guard
    tick();
    clear_in();
    bus.ex_mem_read = 1'b1;
    settle();
    check("zero_guard", outs(), NORM0);

    // Load then branch: two bubbles, state 0 then 1
    tick();
    set_brl();
    settle();
    check("brl_bubble1", outs(), STALL0);
    tick();
    clear_in();
    settle();
    check("brl_bubble2", outs(), STALL1);
    tick();
    settle();
    check("brl_done", outs(), NORM0);

    // ALU result feeding branch (BR1): one bubble, flush suppressed
    tick();
    bus.id_is_branch = 1'b1; bus.branch_taken = 1'b1;
    bus.ex_reg_write = 1'b1; bus.ex_write_reg = 5'd5; bus.id_rs = 5'd5;
    settle();
    check("br1_over_flush", outs(), STALL0);
    tick();
    bus.ex_reg_write = 1'b0; bus.ex_write_reg = '0;
    settle();
    check("taken_flush", outs(), FLUSH0);

    // Non-branch ALU producer needs only forwarding
    tick();
    clear_in();
    bus.ex_reg_write = 1'b1; bus.ex_write_reg = 5'd5; bus.id_rs = 5'd5;
    settle();
    check("alu_no_stall", outs(), NORM0);

    // Load in MEM feeding branch (BRM)
    tick();
    clear_in();
    bus.id_is_branch = 1'b1; bus.mem_mem_read = 1'b1;
    bus.mem_write_reg = 5'd7; bus.id_rt = 5'd7; bus.id_uses_rt = 1'b1;
    settle();
    check("brm_stall", outs(), STALL0);

    // dmem_ready without a request is ignored
    tick();
    clear_in();
    bus.dmem_ready = 1'b1;
    settle();
    check("ready_no_req", outs(), NORM0);

    // Hold beats stall; memory wait from RUN
    tick();
    clear_in();
    bus.dmem_req = 1'b1;
    bus.ex_mem_read = 1'b1; bus.ex_write_reg = 5'd8; bus.id_rs = 5'd8;
    settle();
    check("hold_over_stall", outs(), HOLD0);
    tick();
    settle();
    check("run_wait", outs(), HOLD2);
    tick();
    bus.ex_mem_read = 1'b0;
    bus.dmem_ready = 1'b1;
    settle();
    check("run_wait_release", outs(), NORM2);
    tick();
    clear_in();
    settle();
    check("run_wait_back", outs(), NORM0);

    // Memory wait while the second BRL bubble is pending
    tick();
    set_brl();
    settle();
    check("s2w_bubble1", outs(), STALL0);
    tick();
    clear_in();
    bus.dmem_req = 1'b1;
    settle();
    check("s2w_hold1", outs(), HOLD1);
    for (int i = 0; i < 2; i++) begin
      tick();
      settle();
      check($sformatf("s2w_hold%0d", i + 2), outs(), HOLD2);
    end
    tick();
    bus.dmem_ready = 1'b1;
    settle();
    check("s2w_bubble2", outs(), STALL2);
    tick();
    clear_in();
    settle();
    check("s2w_back_run", outs(), NORM0);

    // Asynchronous reset in MEM_WAIT
    tick();
    bus.dmem_req = 1'b1;
    settle();
    tick();
    settle();
    check("pre_reset_wait", outs(), HOLD2);
    clear_in();
    rst_n = 1'b0;
    #1;
    check("async_reset", outs(), NORM0);
`ifdef HAZARD_STATS_EN
    check("async_reset_stall_cnt", bus.stall_cycles, 0);
    check("async_reset_hold_cnt", bus.hold_cycles, 0);
`endif
    tick();
    rst_n = 1'b1;
    settle();
    check("after_reset", outs(), NORM0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
